mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multi-cycle control unit for the MIPS datapath: a five-state FSM that decodes the instruction register's `op`/`func` fields and sequences the datapath. It drives the 4-bit `aluc` code that the ALU consumes, the ALU operand selects, and the register-file, memory, PC and IR write enables. It consumes the ALU `zero` flag for branch resolution and a `mem_ready` handshake from the shared instruction/data memory.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock.
- `clrn`  input  1  asynchronous active-low reset.
- `op`  input  6  IR[31:26]; valid from ID onward.
- `func`  input  6  IR[5:0]; valid from ID onward.
- `zero`  input  1  ALU equality flag.
- `mem_ready`  input  1  memory access completes this cycle.
- `aluc`  output  4  ALU operation code.
- `alusrca`  output  1  ALU A operand: 0 = PC, 1 = register A.
- `alusrcb`  output  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = immediate, 11 = sext(imm)<<2.
- `shift`  output  1  ALU A operand is `sa` (overrides `alusrca`).
- `sext`  output  1  sign-extend the immediate (0 = zero-extend).
- `iord`  output  1  memory address: 0 = PC, 1 = ALUout.
- `wpc`, `wir`, `wmem`, `wreg`  output  1 each  PC, IR, memory and register-file write enables.
- `pcsrc`  output  2  next PC: 00 = ALU, 01 = ALUout (branch target), 10 = register A, 11 = jump address.
- `regrt`  output  1  destination register is rt (0 = rd).
- `m2reg`  output  1  write-back data is the memory data register.
- `jal`  output  1  write PC+4 to r31.
- `illegal`  output  1  one-cycle pulse on an undecodable instruction.
- `state`  output  3  current state, for debug.

## Operation
- State encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4. Unused encodings go to IF on the next clock.
- Outputs are combinational in `state`, `op`, `func`, `zero` and `mem_ready`. Any output not listed for a state is 0.
- `aluc` codes (the don't-care MSB is driven 0): add 0000, sub 0100, and 0001, or 0101, xor 0010, sll 0011, srl 0111, sra 1111.
- **IF:** `iord`=0, `alusrca`=0, `alusrcb`=01, `aluc`=add.
  - If `mem_ready`: `wir`=1, `wpc`=1, `pcsrc`=00, next state ID.
  - Otherwise: stay in IF with all write enables 0.
- **ID:** `alusrca`=0, `alusrcb`=11, `sext`=1, `aluc`=add; this captures the branch target.
  - j: `wpc`=1, `pcsrc`=11, next IF.
  - jal: also `jal`=1 and `wreg`=1.
  - jr (op 000000, func 001000): `wpc`=1, `pcsrc`=10, next IF.
  - Illegal op/func: `illegal`=1, next IF, no write enables; the instruction is treated as a nop.
  - All other instructions go to EXE.
- **EXE:** `alusrca`=1.
  - R-type add/sub/and/or/xor (func 100000/100010/100100/100101/100110): `alusrcb`=00, matching `aluc`, next WB.
  - sll/srl/sra (func 000000/000010/000011): `shift`=1, `alusrcb`=00, matching `aluc`, next WB.
  - addi/andi/ori/xori (op 001000/001100/001101/001110): `alusrcb`=10, `sext`=1 only for addi, matching `aluc`, next WB.
  - lw/sw (op 100011/101011): `alusrcb`=10, `sext`=1, `aluc`=add, next MEM.
  - beq/bne (op 000100/000101): `alusrcb`=00, `aluc`=sub. If (beq & `zero`) | (bne & !`zero`) then `wpc`=1 and `pcsrc`=01. Next IF.
- **MEM:** `iord`=1.
  - sw: `wmem`=1 every cycle spent in MEM.
  - Stay in MEM until `mem_ready`; then sw goes to IF and lw goes to WB.
- **WB:** `wreg`=1. `regrt`=1 for I-type. `m2reg`=1 for lw. Next IF.

## Timing
- Reset: while `clrn`=0, `state`=IF and all write enables and `illegal` are forced to 0. The FSM leaves reset in IF on the first clock edge after `clrn` rises.
- Reset asserted mid-instruction returns the FSM to IF immediately (asynchronously), and no further writes occur.
- Cycle counts with `mem_ready` held at 1:
  - j/jal/jr: 2 cycles.
  - Branch: 3 cycles.
  - R-type and I-type ALU: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle with `mem_ready`=0 in IF or MEM adds exactly one cycle.
- A write enable generated in a state takes effect at the clock edge that ends that state.

## Configuration
- `MCCU_JAL_EN` defined: jal and jr decode as described above.
- `MCCU_JAL_EN` undefined: jal and jr are illegal. They pulse `illegal` in ID and return to IF. `jal` is tied to 0.

## Test plan
- Reset: hold `clrn`=0 for 3 cycles with `mem_ready`=1 → `state`=0, `wpc`=`wir`=0; first edge after release → `state`=1.
- add (op 000000, func 100000), `mem_ready`=1 → states 0,1,2,4,0. In EXE `aluc`=0000, `alusrcb`=00. In WB `wreg`=1, `regrt`=0.
- sra (func 000011) → EXE `aluc`=1111, `shift`=1. ori (op 001101) → `aluc`=0101, `sext`=0, WB `regrt`=1.
- lw with `mem_ready` low for 2 cycles in MEM → states 0,1,2,3,3,3,4,0. In WB `m2reg`=1. sw → `wmem`=1 in every MEM cycle, then IF.
- beq with `zero`=1 → EXE `wpc`=1, `pcsrc`=01. beq with `zero`=0 → `wpc`=0. bne inverts both results.
- jal: with `MCCU_JAL_EN` → ID `wpc`=1, `pcsrc`=11, `jal`=1, `wreg`=1, then IF. Without the macro → `illegal`=1 for one cycle and no writes. Op 111111 → `illegal` pulse in either build.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// Control bundle between the multi-cycle control unit and the MIPS datapath.
// master: the control unit (consumes IR fields and flags, drives controls).
// slave:  the datapath side (drives IR fields and flags, consumes controls).
interface mc_control_unit_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic [3:0] aluc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       shift;
    logic       sext;
    logic       iord;
    logic       wpc;
    logic       wir;
    logic       wmem;
    logic       wreg;
    logic [1:0] pcsrc;
    logic       regrt;
    logic       m2reg;
    logic       jal;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  op, func, zero, mem_ready,
        output aluc, alusrca, alusrcb, shift, sext, iord, wpc, wir, wmem,
               wreg, pcsrc, regrt, m2reg, jal, illegal, state
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  aluc, alusrca, alusrcb, shift, sext, iord, wpc, wir, wmem,
               wreg, pcsrc, regrt, m2reg, jal, illegal, state
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: five-state FSM (IF, ID, EXE, MEM, WB)
// sequencing the datapath from the IR op/func fields.
// Optional feature macro: MCCU_JAL_EN enables jal and jr decoding; without
// it both are treated as illegal instructions and jal is tied to 0.
module mc_control_unit (
    input  logic              clk,
    input  logic              clrn,
    mc_control_unit_if.master ctl
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0100,
        ALU_AND = 4'b0001,
        ALU_OR  = 4'b0101,
        ALU_XOR = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SRL = 4'b0111,
        ALU_SRA = 4'b1111
    } alu_e;

    typedef enum logic [3:0] {
        C_ILL, C_RALU, C_SHIFT, C_IALU, C_LW, C_SW,
        C_BEQ, C_BNE, C_J, C_JAL, C_JR
    } cls_e;

    state_e r_state;
    state_e w_next;
    cls_e   w_cls;
    alu_e   w_alu;
    logic   w_taken;

    // Instruction decode: classify op/func and pick the ALU operation.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_cls = C_ILL;
        w_alu = ALU_ADD;
        unique case (ctl.op)
            6'b000000: begin
                unique case (ctl.func)
                    6'b100000: begin w_cls = C_RALU;  w_alu = ALU_ADD; end
                    6'b100010: begin w_cls = C_RALU;  w_alu = ALU_SUB; end
                    6'b100100: begin w_cls = C_RALU;  w_alu = ALU_AND; end
                    6'b100101: begin w_cls = C_RALU;  w_alu = ALU_OR;  end
                    6'b100110: begin w_cls = C_RALU;  w_alu = ALU_XOR; end
                    6'b000000: begin w_cls = C_SHIFT; w_alu = ALU_SLL; end
                    6'b000010: begin w_cls = C_SHIFT; w_alu = ALU_SRL; end
                    6'b000011: begin w_cls = C_SHIFT; w_alu = ALU_SRA; end
`ifdef MCCU_JAL_EN
                    6'b001000: w_cls = C_JR;
`endif
                    default:   w_cls = C_ILL;
                endcase
            end
            6'b001000: begin w_cls = C_IALU; w_alu = ALU_ADD; end
            6'b001100: begin w_cls = C_IALU; w_alu = ALU_AND; end
            6'b001101: begin w_cls = C_IALU; w_alu = ALU_OR;  end
            6'b001110: begin w_cls = C_IALU; w_alu = ALU_XOR; end
            6'b100011: w_cls = C_LW;
            6'b101011: w_cls = C_SW;
            6'b000100: begin w_cls = C_BEQ; w_alu = ALU_SUB; end
            6'b000101: begin w_cls = C_BNE; w_alu = ALU_SUB; end
            6'b000010: w_cls = C_J;
`ifdef MCCU_JAL_EN
            6'b000011: w_cls = C_JAL;
`endif
            default:   w_cls = C_ILL;
        endcase
    end

    assign w_taken = ((w_cls == C_BEQ) &&  ctl.zero) ||
                     ((w_cls == C_BNE) && !ctl.zero);

    // Per-state control outputs and next-state selection.
    always_comb begin
        w_next      = S_IF;
        ctl.aluc    = ALU_ADD;
        ctl.alusrca = 1'b0;
        ctl.alusrcb = 2'b00;
        ctl.shift   = 1'b0;
        ctl.sext    = 1'b0;
        ctl.iord    = 1'b0;
        ctl.wpc     = 1'b0;
        ctl.wir     = 1'b0;
        ctl.wmem    = 1'b0;
        ctl.wreg    = 1'b0;
        ctl.pcsrc   = 2'b00;
        ctl.regrt   = 1'b0;
        ctl.m2reg   = 1'b0;
        ctl.jal     = 1'b0;
        ctl.illegal = 1'b0;
        case (r_state)
            S_IF: begin
                ctl.alusrcb = 2'b01;
                if (ctl.mem_ready) begin
                    ctl.wir = 1'b1;
                    ctl.wpc = 1'b1;
                    w_next  = S_ID;
                end else begin
                    w_next  = S_IF;
                end
            end
            S_ID: begin
                // PC + (sext(imm) << 2) is computed here as the branch target.
                ctl.alusrcb = 2'b11;
                ctl.sext    = 1'b1;
                case (w_cls)
                    C_J:   begin ctl.wpc = 1'b1; ctl.pcsrc = 2'b11; end
                    C_JAL: begin
                        ctl.wpc   = 1'b1;
                        ctl.pcsrc = 2'b11;
                        ctl.jal   = 1'b1;
                        ctl.wreg  = 1'b1;
                    end
                    C_JR:  begin ctl.wpc = 1'b1; ctl.pcsrc = 2'b10; end
                    C_ILL: ctl.illegal = 1'b1;
                    default: w_next = S_EXE;
                endcase
            end
            S_EXE: begin
                ctl.alusrca = 1'b1;
                case (w_cls)
                    C_RALU: begin ctl.aluc = w_alu; w_next = S_WB; end
                    C_SHIFT: begin
                        ctl.aluc  = w_alu;
                        ctl.shift = 1'b1;
                        w_next    = S_WB;
                    end
                    C_IALU: begin
                        ctl.aluc    = w_alu;
                        ctl.alusrcb = 2'b10;
                        ctl.sext    = (ctl.op == 6'b001000);
                        w_next      = S_WB;
                    end
                    C_LW, C_SW: begin
                        ctl.alusrcb = 2'b10;
                        ctl.sext    = 1'b1;
                        w_next      = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        ctl.aluc = ALU_SUB;
                        if (w_taken) begin
                            ctl.wpc   = 1'b1;
                            ctl.pcsrc = 2'b01;
                        end
                    end
                    default: w_next = S_IF;
                endcase
            end
            S_MEM: begin
                ctl.iord = 1'b1;
                ctl.wmem = (w_cls == C_SW);
                if (!ctl.mem_ready)    w_next = S_MEM;
                else if (w_cls == C_LW) w_next = S_WB;
                else                   w_next = S_IF;
            end
            S_WB: begin
                ctl.wreg  = 1'b1;
                ctl.regrt = (w_cls == C_IALU) || (w_cls == C_LW);
                ctl.m2reg = (w_cls == C_LW);
            end
            default: w_next = S_IF;
        endcase
        // NOTE: reset must also silence the combinational write enables,
        // otherwise IF with mem_ready=1 would write PC/IR during reset.
        if (!clrn) begin
            ctl.wpc     = 1'b0;
            ctl.wir     = 1'b0;
            ctl.wmem    = 1'b0;
            ctl.wreg    = 1'b0;
            ctl.illegal = 1'b0;
        end
    end

    assign ctl.state = r_state;

    // State register with asynchronous return to IF.
    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: state updates use non-blocking assignment to avoid races.
        if (!clrn) r_state <= S_IF;
        else       r_state <= w_next;
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: the driver pushes the expected
// output vector for each cycle it drives; the monitor pops and compares
// mid-cycle. Expectations follow MCCU_JAL_EN when it is defined.
module tb_mc_control_unit;
    typedef struct packed {
        logic [2:0] state;
        logic [3:0] aluc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       shift;
        logic       sext;
        logic       iord;
        logic       wpc;
        logic       wir;
        logic       wmem;
        logic       wreg;
        logic [1:0] pcsrc;
        logic       regrt;
        logic       m2reg;
        logic       jal;
        logic       illegal;
    } outv_t;

    typedef struct {
        string name;
        outv_t v;
    } exp_t;

    logic clk;
    logic clrn;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    mc_control_unit_if bus ();

    mc_control_unit dut (
        .clk  (clk),
        .clrn (clrn),
        .ctl  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected-vector builders, one per state as described for the unit.
    function automatic outv_t x_if(input bit rdy);
        outv_t o = '0;
        o.alusrcb = 2'b01;
        o.wir = rdy;
        o.wpc = rdy;
        return o;
    endfunction

    function automatic outv_t x_id();
        outv_t o = '0;
        o.state = 3'd1;
        o.alusrcb = 2'b11;
        o.sext = 1'b1;
        return o;
    endfunction

    function automatic outv_t x_exe(input logic [3:0] aluc, input logic [1:0] srcb,
                                    input bit sh, input bit sx);
        outv_t o = '0;
        o.state = 3'd2;
        o.alusrca = 1'b1;
        o.aluc = aluc;
        o.alusrcb = srcb;
        o.shift = sh;
        o.sext = sx;
        return o;
    endfunction

    function automatic outv_t x_mem(input bit is_sw);
        outv_t o = '0;
        o.state = 3'd3;
        o.iord = 1'b1;
        o.wmem = is_sw;
        return o;
    endfunction

    function automatic outv_t x_wb(input bit rt, input bit m2r);
        outv_t o = '0;
        o.state = 3'd4;
        o.wreg = 1'b1;
        o.regrt = rt;
        o.m2reg = m2r;
        return o;
    endfunction

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    initial begin
        exp_t  e;
        outv_t got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {bus.state, bus.aluc, bus.alusrca, bus.alusrcb, bus.shift,
                       bus.sext, bus.iord, bus.wpc, bus.wir, bus.wmem, bus.wreg,
                       bus.pcsrc, bus.regrt, bus.m2reg, bus.jal, bus.illegal};
                n_vec++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL %s: actual=%b required=%b (state %0d vs %0d)",
                             e.name, got, e.v, got.state, e.v.state);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue the response expected during it.
    task automatic cyc(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r, input outv_t e);
        exp_t x;
        bus.op = o;
        bus.func = f;
        bus.zero = z;
        bus.mem_ready = r;
        x.name = nm;
        x.v = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input string nm, input logic [5:0] o, input logic [5:0] f,
                           input outv_t exe, input bit itype);
        cyc({nm, "_if"},  o, f, 1'b0, 1'b1, x_if(1));
        cyc({nm, "_id"},  o, f, 1'b0, 1'b1, x_id());
        cyc({nm, "_exe"}, o, f, 1'b0, 1'b1, exe);
        cyc({nm, "_wb"},  o, f, 1'b0, 1'b1, x_wb(itype, 1'b0));
    endtask

    task automatic run_br(input string nm, input logic [5:0] o, input logic z,
                          input bit taken);
        outv_t e = x_exe(4'b0100, 2'b00, 1'b0, 1'b0);
        if (taken) begin
            e.wpc = 1'b1;
            e.pcsrc = 2'b01;
        end
        cyc({nm, "_if"},  o, 6'd0, z, 1'b1, x_if(1));
        cyc({nm, "_id"},  o, 6'd0, z, 1'b1, x_id());
        cyc({nm, "_exe"}, o, 6'd0, z, 1'b1, e);
    endtask

    task automatic run_id(input string nm, input logic [5:0] o, input logic [5:0] f,
                          input outv_t idv);
        cyc({nm, "_if"}, o, f, 1'b0, 1'b1, x_if(1));
        cyc({nm, "_id"}, o, f, 1'b0, 1'b1, idv);
    endtask

    initial begin
        outv_t e;
        clrn = 1'b0;
        bus.op = 6'd0;
        bus.func = 6'b100000;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held for three cycles: IF with enables forced off.
        for (int i = 0; i < 3; i++)
            cyc("reset", 6'd0, 6'b100000, 1'b0, 1'b1, x_if(0));
        clrn = 1'b1;

        run_alu("add", 6'b000000, 6'b100000, x_exe(4'b0000, 2'b00, 1'b0, 1'b0), 1'b0);

        cyc("if_wait", 6'b000000, 6'b000011, 1'b0, 1'b0, x_if(0));
        run_alu("sra",  6'b000000, 6'b000011, x_exe(4'b1111, 2'b00, 1'b1, 1'b0), 1'b0);
        run_alu("sub",  6'b000000, 6'b100010, x_exe(4'b0100, 2'b00, 1'b0, 1'b0), 1'b0);
        run_alu("srl",  6'b000000, 6'b000010, x_exe(4'b0111, 2'b00, 1'b1, 1'b0), 1'b0);
        run_alu("ori",  6'b001101, 6'd0,      x_exe(4'b0101, 2'b10, 1'b0, 1'b0), 1'b1);
        run_alu("addi", 6'b001000, 6'd0,      x_exe(4'b0000, 2'b10, 1'b0, 1'b1), 1'b1);
        run_alu("xori", 6'b001110, 6'd0,      x_exe(4'b0010, 2'b10, 1'b0, 1'b0), 1'b1);

        // lw with two wait cycles in MEM.
        cyc("lw_if",   6'b100011, 6'd0, 1'b0, 1'b1, x_if(1));
        cyc("lw_id",   6'b100011, 6'd0, 1'b0, 1'b1, x_id());
        cyc("lw_exe",  6'b100011, 6'd0, 1'b0, 1'b1, x_exe(4'b0000, 2'b10, 1'b0, 1'b1));
        cyc("lw_mem0", 6'b100011, 6'd0, 1'b0, 1'b0, x_mem(0));
        cyc("lw_mem1", 6'b100011, 6'd0, 1'b0, 1'b0, x_mem(0));
        cyc("lw_mem2", 6'b100011, 6'd0, 1'b0, 1'b1, x_mem(0));
        cyc("lw_wb",   6'b100011, 6'd0, 1'b0, 1'b1, x_wb(1'b1, 1'b1));

        // sw with one wait cycle in MEM, then straight back to IF.
        cyc("sw_if",   6'b101011, 6'd0, 1'b0, 1'b1, x_if(1));
        cyc("sw_id",   6'b101011, 6'd0, 1'b0, 1'b1, x_id());
        cyc("sw_exe",  6'b101011, 6'd0, 1'b0, 1'b1, x_exe(4'b0000, 2'b10, 1'b0, 1'b1));
        cyc("sw_mem0", 6'b101011, 6'd0, 1'b0, 1'b0, x_mem(1));
        cyc("sw_mem1", 6'b101011, 6'd0, 1'b0, 1'b1, x_mem(1));

        run_br("beq_z1", 6'b000100, 1'b1, 1'b1);
        run_br("beq_z0", 6'b000100, 1'b0, 1'b0);
        run_br("bne_z1", 6'b000101, 1'b1, 1'b0);
        run_br("bne_z0", 6'b000101, 1'b0, 1'b1);

        e = x_id();
        e.wpc = 1'b1;
        e.pcsrc = 2'b11;
        run_id("j", 6'b000010, 6'd0, e);

        e = x_id();
`ifdef MCCU_JAL_EN
        e.wpc = 1'b1;
        e.pcsrc = 2'b11;
        e.jal = 1'b1;
        e.wreg = 1'b1;
`else
        e.illegal = 1'b1;
`endif
        run_id("jal", 6'b000011, 6'd0, e);

        e = x_id();
`ifdef MCCU_JAL_EN
        e.wpc = 1'b1;
        e.pcsrc = 2'b10;
`else
        e.illegal = 1'b1;
`endif
        run_id("jr", 6'b000000, 6'b001000, e);

        e = x_id();
        e.illegal = 1'b1;
        run_id("op_3f", 6'b111111, 6'd0, e);
        run_id("bad_func", 6'b000000, 6'b111111, e);

        // Asynchronous reset in the middle of an add, during EXE.
        cyc("mid_if", 6'b000000, 6'b100000, 1'b0, 1'b1, x_if(1));
        cyc("mid_id", 6'b000000, 6'b100000, 1'b0, 1'b1, x_id());
        clrn = 1'b0;
        cyc("mid_rst", 6'b000000, 6'b100000, 1'b0, 1'b1, x_if(0));
        clrn = 1'b1;
        run_alu("and_after_rst", 6'b000000, 6'b100100,
                x_exe(4'b0001, 2'b00, 1'b0, 1'b0), 1'b0);
        cyc("final_if", 6'b000000, 6'b100000, 1'b0, 1'b0, x_if(0));

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
